// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word memory between instruction fetch
// (read-only) and data load/store. Grants are combinational and read data is
// registered, so each requester sees its response one cycle after acceptance.
// Default build: data has priority over fetch, and a starvation counter forces
// a fetch grant after STARVE_LIMIT consecutive denied cycles.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: replaces fixed priority and the
// starvation counter with two-way round-robin arbitration.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_readaddr,
  input  logic [31:0] mem_readdata,
  output logic [31:0] mem_writeaddr,
  output logic [31:0] mem_writedata,
  output logic        mem_writeenable
);

  // Grant decision for this cycle
  logic        gnt_if_s;
  logic        gnt_d_s;

  // Response registers
  logic        if_rvalid_q, if_rvalid_d;
  logic        d_rvalid_q,  d_rvalid_d;
  logic [31:0] if_rdata_q,  if_rdata_d;
  logic [31:0] d_rdata_q,   d_rdata_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  grant_e last_grant_q, last_grant_d;

  // Round-robin grant: on contention the side not granted last wins
  always_comb begin
    gnt_if_s = 1'b0;
    gnt_d_s  = 1'b0;
    if (reset) begin
      gnt_if_s = 1'b0;
      gnt_d_s  = 1'b0;
    end else if (if_req && d_req) begin
      if (last_grant_q == GRANT_DATA) begin
        gnt_if_s = 1'b1;
      end else begin
        gnt_d_s = 1'b1;
      end
    end else if (d_req) begin
      gnt_d_s = 1'b1;
    end else if (if_req) begin
      gnt_if_s = 1'b1;
    end else begin
      gnt_if_s = 1'b0;
      gnt_d_s  = 1'b0;
    end
  end

  // Remember the side granted most recently; idle cycles leave it unchanged
  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_d_s) begin
      last_grant_d = GRANT_DATA;
    end else if (gnt_if_s) begin
      last_grant_d = GRANT_FETCH;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Round-robin pointer register; fetch counts as last so data wins first
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= GRANT_FETCH;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  localparam logic [CNT_W-1:0] STARVE_LIM_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX_C    = {CNT_W{1'b1}};

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Fixed priority (data first) with a starvation override for fetch
  always_comb begin
    gnt_if_s = 1'b0;
    gnt_d_s  = 1'b0;
    if (reset) begin
      gnt_if_s = 1'b0;
      gnt_d_s  = 1'b0;
    end else if (if_req && (starve_cnt_q >= STARVE_LIM_C)) begin
      gnt_if_s = 1'b1;
    end else if (d_req) begin
      gnt_d_s = 1'b1;
    end else if (if_req) begin
      gnt_if_s = 1'b1;
    end else begin
      gnt_if_s = 1'b0;
      gnt_d_s  = 1'b0;
    end
  end

  // Count consecutive denied fetch cycles, saturating at the counter maximum
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_req && !gnt_if_s) begin
      if (starve_cnt_q != CNT_MAX_C) begin
        starve_cnt_d = starve_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else begin
      starve_cnt_d = {CNT_W{1'b0}};
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= {CNT_W{1'b0}};
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // Capture read data for the granted side only; a store only acknowledges
  always_comb begin
    if_rvalid_d = gnt_if_s;
    d_rvalid_d  = gnt_d_s;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if (gnt_if_s) begin
      if_rdata_d = mem_readdata;
    end else begin
      if_rdata_d = if_rdata_q;
    end
    if (gnt_d_s && !d_we) begin
      d_rdata_d = mem_readdata;
    end else begin
      d_rdata_d = d_rdata_q;
    end
  end

  // Response registers; reset drops any response still in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= 32'h0000_0000;
      d_rdata_q   <= 32'h0000_0000;
    end else begin
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Output drive: responses are masked while reset is high so a pending
  // response is never seen; the write strobe follows the data grant so the
  // store lands on the same edge that accepts it
  always_comb begin
    if_gnt          = gnt_if_s;
    d_gnt           = gnt_d_s;
    mem_writeenable = gnt_d_s & d_we;
    if_rvalid       = 1'b0;
    d_rvalid        = 1'b0;
    if_rdata        = 32'h0000_0000;
    d_rdata         = 32'h0000_0000;
    mem_writeaddr   = 32'h0000_0000;
    mem_writedata   = 32'h0000_0000;
    if (reset) begin
      if_rvalid     = 1'b0;
      d_rvalid      = 1'b0;
      if_rdata      = 32'h0000_0000;
      d_rdata       = 32'h0000_0000;
      mem_writeaddr = 32'h0000_0000;
      mem_writedata = 32'h0000_0000;
    end else begin
      if_rvalid     = if_rvalid_q;
      d_rvalid      = d_rvalid_q;
      if_rdata      = if_rdata_q;
      d_rdata       = d_rdata_q;
      mem_writeaddr = d_addr;
      mem_writedata = d_wdata;
    end
    if (gnt_d_s) begin
      mem_readaddr = d_addr;
    end else if (gnt_if_s) begin
      mem_readaddr = if_addr;
    end else begin
      mem_readaddr = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a behavioural word memory, a negedge monitor with
// an arbitration model and response scoreboard, directed cases and a random
// phase. Define MEM_ARB_ROUND_ROBIN_EN to check the round-robin build.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_writeenable;
  logic [31:0] if_rdata, d_rdata, mem_readaddr, mem_readdata;
  logic [31:0] mem_writeaddr, mem_writedata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_readaddr(mem_readaddr), .mem_readdata(mem_readdata),
    .mem_writeaddr(mem_writeaddr), .mem_writedata(mem_writedata),
    .mem_writeenable(mem_writeenable)
  );

  // Behavioural memory: combinational read, write on posedge
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  assign mem_readdata = mem[mem_readaddr[7:2]];
  always @(posedge clk) if (mem_writeenable) mem[mem_writeaddr[7:2]] <= mem_writedata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];
  logic        m_if_pend = 1'b0, m_d_pend = 1'b0;
  logic        m_if_g = 1'b0, m_d_g = 1'b0;
  logic [31:0] m_d_rdata = 32'h0;
  int          m_cnt = 0;
  logic        m_last_d = 1'b0;
  logic        e_if, e_d;
  logic [31:0] e_ra, popped;

  // Monitor: expected grants and scoreboarded responses, sampled mid-cycle
  always @(negedge clk) begin
    e_if = 1'b0;
    e_d  = 1'b0;
    if (!reset) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (if_req && d_req) begin
        e_if = m_last_d;
        e_d  = !m_last_d;
      end else begin
        e_d  = d_req;
        e_if = if_req && !d_req;
      end
`else
      if (if_req && m_cnt >= 4) e_if = 1'b1;
      else if (d_req) e_d = 1'b1;
      else if (if_req) e_if = 1'b1;
`endif
    end
    check_eq("if_gnt", {31'h0, if_gnt}, {31'h0, e_if});
    check_eq("d_gnt", {31'h0, d_gnt}, {31'h0, e_d});
    check_eq("mem_we", {31'h0, mem_writeenable}, {31'h0, e_d & d_we});
    e_ra = e_d ? d_addr : (e_if ? if_addr : 32'h0);
    check_eq("mem_readaddr", mem_readaddr, e_ra);

    if (reset) begin
      check_eq("rst_if_rvalid", {31'h0, if_rvalid}, 32'h0);
      check_eq("rst_d_rvalid", {31'h0, d_rvalid}, 32'h0);
      check_eq("rst_if_rdata", if_rdata, 32'h0);
      check_eq("rst_d_rdata", d_rdata, 32'h0);
      exp_if_q.delete();
      exp_d_q.delete();
      m_if_pend = 1'b0; m_d_pend = 1'b0;
      m_cnt = 0; m_last_d = 1'b0; m_d_rdata = 32'h0;
      m_if_g = 1'b0; m_d_g = 1'b0;
    end else begin
      check_eq("if_rvalid", {31'h0, if_rvalid}, {31'h0, m_if_pend});
      if (m_if_pend) begin
        if (exp_if_q.size() == 0) check_eq("if_q_empty", 32'h1, 32'h0);
        else begin
          popped = exp_if_q.pop_front();
          check_eq("if_rdata", if_rdata, popped);
        end
      end
      check_eq("d_rvalid", {31'h0, d_rvalid}, {31'h0, m_d_pend});
      if (m_d_pend) begin
        if (exp_d_q.size() == 0) check_eq("d_q_empty", 32'h1, 32'h0);
        else begin
          popped = exp_d_q.pop_front();
          check_eq("d_rdata", d_rdata, popped);
        end
      end
      // Advance the model for the coming edge
      if (e_if) exp_if_q.push_back(ref_mem[if_addr[7:2]]);
      if (e_d) begin
        if (d_we) ref_mem[d_addr[7:2]] = d_wdata;
        else m_d_rdata = ref_mem[d_addr[7:2]];
        exp_d_q.push_back(m_d_rdata);
        m_last_d = 1'b1;
      end
      if (e_if) m_last_d = 1'b0;
      if (if_req && !e_if) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
      else m_cnt = 0;
      m_if_pend = e_if;
      m_d_pend  = e_d;
      m_if_g = e_if;
      m_d_g  = e_d;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_ifg;
    logic [31:0] word12;
    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    mem[3] = 32'hDEAD_BEEF;
    ref_mem[3] = 32'hDEAD_BEEF;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    // Fetch-only read of word 3
    if_req = 1'b1; if_addr = 32'h0000_000C;
    @(negedge clk);
    check_eq("t1_if_gnt", {31'h0, if_gnt}, 32'h1);
    cyc();
    if_req = 1'b0;
    @(negedge clk);
    check_eq("t1_if_rvalid", {31'h0, if_rvalid}, 32'h1);
    check_eq("t1_if_rdata", if_rdata, 32'hDEAD_BEEF);
    check_eq("t1_d_rvalid", {31'h0, d_rvalid}, 32'h0);
    cyc();

    // Store and fetch to the same word: store first, fetch sees new data
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h1234_5678;
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check_eq("t2_d_gnt", {31'h0, d_gnt}, 32'h1);
    check_eq("t2_we", {31'h0, mem_writeenable}, 32'h1);
    cyc();
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check_eq("t2_if_gnt", {31'h0, if_gnt}, 32'h1);
    cyc();
    if_req = 1'b0;
    @(negedge clk);
    check_eq("t2_if_rdata", if_rdata, 32'h1234_5678);
    cyc();

    // Both requesting for 10 cycles
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; if_req = 1'b1; if_addr = 32'h24;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_ifg = (i % 2) == 1;
`else
      exp_ifg = (i == 4) || (i == 9);
`endif
      check_eq("t3_if_gnt", {31'h0, if_gnt}, {31'h0, exp_ifg});
      check_eq("t3_d_gnt", {31'h0, d_gnt}, {31'h0, !exp_ifg});
      cyc();
    end
    d_req = 1'b0; if_req = 1'b0;
    cyc();

    // Misaligned load returns word 3
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_000F;
    @(negedge clk);
    check_eq("t4_d_gnt", {31'h0, d_gnt}, 32'h1);
    cyc();
    d_req = 1'b0;
    @(negedge clk);
    check_eq("t4_d_rvalid", {31'h0, d_rvalid}, 32'h1);
    check_eq("t4_d_rdata", d_rdata, 32'hDEAD_BEEF);
    cyc();

    // Reset while a load response is in flight, store attempted during reset
    word12 = ref_mem[12];
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0014;
    cyc();
    reset = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    check_eq("t5_d_rvalid", {31'h0, d_rvalid}, 32'h0);
    check_eq("t5_d_gnt", {31'h0, d_gnt}, 32'h0);
    check_eq("t5_we", {31'h0, mem_writeenable}, 32'h0);
    check_eq("t5_d_rdata", d_rdata, 32'h0);
    repeat (2) cyc();
    check_eq("t5_no_write", mem[12], word12);
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    cyc();

    // Random traffic; requests held until accepted
    for (int c = 0; c < 400; c++) begin
      if (!if_req || m_if_g) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 32'($urandom_range(0, 255));
      end
      if (!d_req || m_d_g) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = 32'($urandom_range(0, 255));
        d_wdata = $urandom;
      end
      cyc();
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) cyc();
    for (int i = 0; i < 64; i++) check_eq("mem_word", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port word memory (combinational read, synchronous write, byte address with bits [1:0] ignored) between two requesters: instruction fetch (read-only) and data load/store.
- Sits between the core pipeline and the memory instance.
- Registers read data so each requester sees a one-cycle response.
- Default priority is data over fetch, with a starvation guard for fetch.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles fetch may be denied while requesting; the next cycle fetch wins. Legal range 1..15.
- CNT_W, 4: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk, in, 1: the single clock. All state updates on posedge.
- reset, in, 1: synchronous, active-high reset.
- if_req, in, 1: fetch request.
- if_addr, in, 32: fetch byte address.
- if_gnt, out, 1: fetch accepted this cycle (combinational).
- if_rvalid, out, 1: fetch data valid (one-cycle pulse).
- if_rdata, out, 32: fetch read data (registered).
- d_req, in, 1: data request.
- d_we, in, 1: 1 = store, 0 = load.
- d_addr, in, 32: data byte address.
- d_wdata, in, 32: store data.
- d_gnt, out, 1: data accepted this cycle (combinational).
- d_rvalid, out, 1: load data valid or store acknowledge (one-cycle pulse).
- d_rdata, out, 32: load data (registered).
- mem_readaddr, out, 32: to memory read address.
- mem_readdata, in, 32: from memory (combinational).
- mem_writeaddr, out, 32: to memory write address.
- mem_writedata, out, 32: to memory write data.
- mem_writeenable, out, 1: to memory write strobe.

Behaviour:
- At most one access per cycle.
- Acceptance = req & gnt in the same cycle. Requesters hold req, addr and wdata stable until granted.
- Grant rule (fixed priority, default):
  - starve_cnt >= STARVE_LIMIT and if_req=1 → if_gnt=1, d_gnt=0.
  - else d_req=1 → d_gnt=1, if_gnt=0.
  - else if_req=1 → if_gnt=1.
  - No request → both gnt=0.
- Memory drive:
  - mem_readaddr = granted address; 0 when idle.
  - mem_writeaddr = d_addr; mem_writedata = d_wdata.
  - mem_writeenable = d_gnt & d_we, combinational, so the write lands on the same edge as the grant.
- Read response:
  - On the accept edge, mem_readdata is captured into if_rdata or d_rdata (granted side only). The other side's rdata holds its value.
  - rvalid for the granted side is 1 in the next cycle only. Latency = 1 cycle.
- Store: d_rvalid pulses next cycle; d_rdata is unchanged.
- Back-to-back grants are allowed every cycle. rvalid may be high on consecutive cycles.
- Starvation counter:
  - if_req & ~if_gnt → starve_cnt++, saturating at 2^CNT_W−1.
  - if_gnt or ~if_req → starve_cnt=0.
- Address bits [1:0] are passed through unchanged; the memory ignores them. No alignment fault is raised.
- Simultaneous store and fetch to the same word: store is granted first. A fetch granted later reads the new data.
- Reset:
  - Values: if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, starve_cnt=0, last_grant=fetch.
  - A pending response in flight is dropped (its rvalid is not asserted).
  - gnt outputs and mem_writeenable are forced 0 while reset=1, so no write occurs during reset.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Fixed priority and starve_cnt are replaced by round-robin.
  - When both request, the side not granted last wins. last_grant updates on every grant.
  - A single requester always wins.
  - STARVE_LIMIT is ignored.
- Undefined: fixed priority with starvation guard, as above.

Test Plan:
- Fetch-only read:
  - Stimulus: mem word 3 = 0xDEADBEEF; if_req=1, if_addr=0x0C.
  - Required: if_gnt=1 same cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF; d_rvalid=0.
- Store then fetch, same word:
  - Stimulus: both request; d_we=1, d_addr=0x10, d_wdata=0x12345678; if_addr=0x10.
  - Required: cycle 0 d_gnt=1, mem_writeenable=1; cycle 1 if_gnt=1; cycle 2 if_rdata=0x12345678.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: d_req and if_req held high for 10 cycles.
  - Required: d_gnt for cycles 0–3; if_gnt at cycle 4; pattern repeats (cycle 9 if_gnt).
- Reset mid-operation:
  - Stimulus: load granted at cycle N; reset=1 at cycle N+1.
  - Required: d_rvalid=0 at N+1; all outputs 0; no write during reset even with d_req=d_we=1.
- Misaligned address:
  - Stimulus: d_addr=0x0F load.
  - Required: returns word 3 contents; no error.
- Round-robin (MEM_ARB_ROUND_ROBIN_EN defined):
  - Stimulus: both requesting continuously.
  - Required: grants alternate data/fetch starting with data after reset (last_grant=fetch).
